// File: rtl/led_pattern_seq.sv
// led_pattern_seq: four-animation 8-LED pattern generator with debounced mode key and pause.
// Optional macro LED_PWM_EN gates the registered LED word with an 8-bit PWM frame counter.
module led_pattern_seq #(
  parameter int STEP_CYCLES = 12_500_000,
  parameter int DB_CYCLES   = 1_000_000,
  parameter int PWM_DUTY    = 64
) (
  input  logic       CLK_50M,
  input  logic       RST_N,
  input  logic       KEY_MODE,
  input  logic       PAUSE,
  output logic [7:0] LED,
  output logic [1:0] MODE
);

  localparam int STEP_W = $clog2(STEP_CYCLES);
  localparam int DB_W   = $clog2(DB_CYCLES);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    M0_RUN_L    = 2'd0,
    M1_RUN_R    = 2'd1,
    M2_PINGPONG = 2'd2,
    M3_BLINK    = 2'd3
  } mode_t;

  logic            key_s1, key_s2, key_db, press;
  logic [DB_W-1:0] db_cnt;

  mode_t             state, state_nxt;
  logic [7:0]        pattern, pattern_nxt;
  logic              dir_right, dir_nxt;
  logic [STEP_W-1:0] step_cnt, step_nxt;
  logic              tick;

  function automatic logic [7:0] seed_of(input mode_t m);
    case (m)
      M1_RUN_R: seed_of = 8'h80;
      M3_BLINK: seed_of = 8'h55;
      default:  seed_of = 8'h01;
    endcase
  endfunction

  // Key path: 2-FF synchroniser, then a debouncer that only fires on the press edge
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
      key_db <= 1'b1;
      db_cnt <= '0;
      press  <= 1'b0;
    end else begin
      key_s1 <= KEY_MODE;
      key_s2 <= key_s1;
      press  <= 1'b0;
      if (key_s2 == key_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        key_db <= key_s2;
        db_cnt <= '0;
        press  <= ~key_s2;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  assign tick = (step_cnt == STEP_LAST) && !PAUSE;

  always_comb begin
    state_nxt   = state;
    pattern_nxt = pattern;
    dir_nxt     = dir_right;
    step_nxt    = step_cnt;
    if (!PAUSE) step_nxt = tick ? '0 : step_cnt + STEP_W'(1);
    // A press outranks a coincident tick: the tick is simply dropped
    if (press) begin
      case (state)
        M0_RUN_L:    state_nxt = M1_RUN_R;
        M1_RUN_R:    state_nxt = M2_PINGPONG;
        M2_PINGPONG: state_nxt = M3_BLINK;
        default:     state_nxt = M0_RUN_L;
      endcase
      pattern_nxt = seed_of(state_nxt);
      dir_nxt     = 1'b0;
      step_nxt    = '0;
    end else if (tick) begin
      case (state)
        M0_RUN_L: pattern_nxt = {pattern[6:0], pattern[7]};
        M1_RUN_R: pattern_nxt = {pattern[0], pattern[7:1]};
        M2_PINGPONG: begin
          // Turn around on the endpoint itself so it is never shown twice
          if (!dir_right) begin
            if (pattern[7]) begin
              pattern_nxt = pattern >> 1;
              dir_nxt     = 1'b1;
            end else begin
              pattern_nxt = pattern << 1;
            end
          end else begin
            if (pattern[0]) begin
              pattern_nxt = pattern << 1;
              dir_nxt     = 1'b0;
            end else begin
              pattern_nxt = pattern >> 1;
            end
          end
        end
        default: pattern_nxt = ~pattern;
      endcase
    end
  end

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      state     <= M0_RUN_L;
      pattern   <= 8'h01;
      dir_right <= 1'b0;
      step_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      pattern   <= pattern_nxt;
      dir_right <= dir_nxt;
      step_cnt  <= step_nxt;
    end
  end

  assign MODE = state;

`ifdef LED_PWM_EN
  localparam logic [8:0] PWM_LIM = 9'(PWM_DUTY);

  logic [7:0] frame_cnt;
  logic [7:0] led_q;
  logic       pwm_on;

  assign pwm_on = ({1'b0, frame_cnt} < PWM_LIM);

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      frame_cnt <= '0;
      led_q     <= 8'h01;
    end else begin
      frame_cnt <= frame_cnt + 8'd1;
      led_q     <= pattern_nxt & {8{pwm_on}};
    end
  end

  assign LED = led_q;
`else
  assign LED = pattern;
`endif

endmodule
